// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Brief    : Request/result bundle between the execute stage and div_unit.
// Revision : 1.0
// ============================================================================
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall_div;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_div, ready, hi, lo
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_div, ready, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Radix-2 restoring DIV/DIVU unit for the execute stage, one
//            quotient bit per cycle. DIV_ZERO_FAST_EN enables a one-cycle
//            divide-by-zero shortcut.
// Revision : 1.0
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_LAST_CNT = 5'(WIDTH - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_quotNeg;
  logic             r_remNeg;
  logic             r_ready;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_step;
  logic             w_finish;
  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aAbs;
  logic [WIDTH-1:0] w_bAbs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quotNext;
  logic [WIDTH-1:0] w_loFinal;
  logic [WIDTH-1:0] w_hiFinal;
`ifdef DIV_ZERO_FAST_EN
  logic             w_bZero;
  logic             w_fastZero;
`endif

  // Operand magnitudes; DIVU treats both operands as unsigned positives.
  assign w_aNeg = bus.signed_div & bus.a[WIDTH-1];
  assign w_bNeg = bus.signed_div & bus.b[WIDTH-1];
  assign w_aAbs = w_aNeg ? (~bus.a + 1'b1) : bus.a;
  assign w_bAbs = w_bNeg ? (~bus.b + 1'b1) : bus.b;

  assign w_accept = (r_state == IDLE) & bus.start & ~bus.annul;
  assign w_step   = (r_state == BUSY) & ~bus.annul;
  assign w_finish = w_step & (r_cnt == c_LAST_CNT);

`ifdef DIV_ZERO_FAST_EN
  assign w_bZero    = (bus.b == '0);
  assign w_fastZero = w_accept & w_bZero;
`endif

  // The dividend shifts out of r_quot MSB-first while quotient bits shift in.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_remNext  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quotNext = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_loFinal = r_quotNeg ? (~w_quotNext + 1'b1) : w_quotNext;
  assign w_hiFinal = r_remNeg  ? (~w_remNext  + 1'b1) : w_remNext;

  always_comb begin
    w_stateNext = r_state;
    if (bus.annul) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
`ifdef DIV_ZERO_FAST_EN
            w_stateNext = w_bZero ? DONE : BUSY;
`else
            w_stateNext = BUSY;
`endif
          end
        end
        BUSY: begin
          if (r_cnt == c_LAST_CNT) begin
            w_stateNext = DONE;
          end
        end
        DONE:    w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ready <= (w_stateNext == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_quotNeg <= 1'b0;
      r_remNeg  <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_divisor <= w_bAbs;
      r_quot    <= w_aAbs;
      r_rem     <= '0;
      r_quotNeg <= w_aNeg ^ w_bNeg;
      r_remNeg  <= w_aNeg;
    end else if (w_step) begin
      r_cnt  <= r_cnt + 5'd1;
      r_quot <= w_quotNext;
      r_rem  <= w_remNext;
    end
  end

  // Result registers hold across IDLE until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      r_hi <= w_hiFinal;
      r_lo <= w_loFinal;
`ifdef DIV_ZERO_FAST_EN
    end else if (w_fastZero) begin
      r_hi <= bus.a;
      r_lo <= '1;
`endif
    end
  end

  assign bus.stall_div = bus.start & ~r_ready & ~bus.annul;
  assign bus.ready     = r_ready;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit (latency, results,
//            annul, asynchronous reset, divide-by-zero).
// Revision : 1.0
// ============================================================================
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge (cycle 0); returns just after the
  // edge that follows the ready cycle, with start dropped.
  task automatic doDiv(input string tag, input logic sd, input logic [31:0] av,
                       input logic [31:0] bv, input int expLat, input bit chkRes,
                       input logic [31:0] eLo, input logic [31:0] eHi);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = av;
    bus.b          = bv;
    while (!seen && cyc <= expLat + 5) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1'b1;
      end else begin
        if (cyc == 0 || cyc == expLat - 1)
          checkValue({tag, ".stall"}, {31'd0, bus.stall_div}, 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        bus.a          = ~av;
        bus.b          = ~bv;
        bus.signed_div = ~sd;
      end
    end
    checkValue({tag, ".latency"}, cyc, expLat);
    if (seen) begin
      checkValue({tag, ".stallAtReady"}, {31'd0, bus.stall_div}, 32'd0);
      if (chkRes) begin
        checkValue({tag, ".lo"}, bus.lo, eLo);
        checkValue({tag, ".hi"}, bus.hi, eHi);
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkValue({tag, ".readyDrop"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    int readyCount;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.annul      = 1'b0;
    #2;
    checkValue("reset.ready", {31'd0, bus.ready}, 32'd0);
    checkValue("reset.hi", bus.hi, 32'd0);
    checkValue("reset.lo", bus.lo, 32'd0);
    checkValue("reset.stall", {31'd0, bus.stall_div}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    doDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 1'b1, 32'd14, 32'd2);
    doDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    doDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 1'b1, 32'hFFFF_FFFD, 32'd1);
    doDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 32'h8000_0000, 32'd0);

    // Back-to-back: second request enters in the cycle after ready.
    doDiv("b2b_first", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 1'b1, 32'hFFFF_FFFF, 32'd0);
    doDiv("b2b_second", 1'b0, 32'd9, 32'd3, 33, 1'b1, 32'd3, 32'd0);

    // Annul in cycle 10 of an in-flight divide.
    readyCount     = 0;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd50;
    bus.b          = 32'd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ready) readyCount++;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.annul = 1'b1;
    @(negedge clk);
    checkValue("annul.stall", {31'd0, bus.stall_div}, 32'd0);
    if (bus.ready) readyCount++;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    checkValue("annul.noReady", readyCount, 0);
    checkValue("annul.loKept", bus.lo, 32'd3);
    checkValue("annul.hiKept", bus.hi, 32'd0);
    doDiv("after_annul", 1'b0, 32'd1000, 32'd10, 33, 1'b1, 32'd100, 32'd0);

    // Annul together with start in IDLE: nothing is accepted that cycle.
    bus.start = 1'b1;
    bus.a     = 32'd78;
    bus.b     = 32'd7;
    bus.annul = 1'b1;
    @(negedge clk);
    checkValue("annulWins.stall", {31'd0, bus.stall_div}, 32'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    doDiv("annulWins", 1'b0, 32'd78, 32'd7, 33, 1'b1, 32'd11, 32'd1);

    // Asynchronous reset in cycle 20 of a divide.
    bus.start = 1'b1;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    checkValue("rst.ready", {31'd0, bus.ready}, 32'd0);
    checkValue("rst.hi", bus.hi, 32'd0);
    checkValue("rst.lo", bus.lo, 32'd0);
    checkValue("rst.stallFollowsStart", {31'd0, bus.stall_div}, 32'd1);
    bus.start = 1'b0;
    #1;
    checkValue("rst.stallLow", {31'd0, bus.stall_div}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    doDiv("after_rst", 1'b0, 32'd20, 32'd5, 33, 1'b1, 32'd4, 32'd0);

`ifdef DIV_ZERO_FAST_EN
    doDiv("divzero_u", 1'b0, 32'h1234_5678, 32'd0, 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    doDiv("divzero_s", 1'b1, 32'h8765_4321, 32'd0, 1, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321);
`else
    doDiv("divzero_u", 1'b0, 32'h1234_5678, 32'd0, 33, 1'b0, 32'd0, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
